fetch_stall_unit: RTL

FETCH_STALL_UNIT -- requirements
Module: fetch_stall_unit

---
 rtl/fetch_stall_unit_pkg.sv | 8 +
 rtl/fetch_stall_unit_pipe_reg.sv | 19 +
 rtl/fetch_stall_unit.sv | 75 +++++++
 3 files changed

// File: rtl/fetch_stall_unit_pkg.sv
// Shared constants for the fetch/stall front end: default control width, NOP encodings, reset PC.
package fetch_stall_unit_pkg;
  localparam int          CTRL_WIDTH_DEF = 9;
  localparam int          STALL_CNT_W    = 16;
  localparam logic [63:0] NOP_CTRL       = '0;
  localparam logic [63:0] NOP_INST       = '0;
  localparam logic [63:0] RESET_PC       = '0;
endpackage

// File: rtl/fetch_stall_unit_pipe_reg.sv
// Generic pipeline register: synchronous reset to RST_VAL, synchronous clear to zero, load enable.
module pipe_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Clear beats enable so a flush wins over a hold.
  always_ff @(posedge clk) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end
endmodule

// File: rtl/fetch_stall_unit.sv
// IF-stage PC, IF/ID and ID/EX control registers with hazard stalls and branch flush.
// Define FETCH_STALL_COUNTER_EN to build the saturating load-use stall counter.
module fetch_stall_unit
  import fetch_stall_unit_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_PCWrite,
  input  logic                  i_if_id_write,
  input  logic                  i_control_mux,
  input  logic                  i_branch_taken,
  input  logic [PC_WIDTH-1:0]   i_branch_target,
  input  logic [INST_WIDTH-1:0] i_instruction,
  input  logic [CTRL_WIDTH-1:0] i_id_control,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic [PC_WIDTH-1:0]   o_if_id_pc_plus1,
  output logic [INST_WIDTH-1:0] o_if_id_instruction,
  output logic                  o_if_id_valid,
  output logic [CTRL_WIDTH-1:0] o_id_ex_control,
  output logic [15:0]           o_stall_count
);
  localparam int IFID_W = PC_WIDTH + INST_WIDTH + 1;

  logic [PC_WIDTH-1:0]   pc_plus1;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [IFID_W-1:0]     ifid_d, ifid_q;
  logic [CTRL_WIDTH-1:0] idex_d;

  assign pc_plus1 = o_pc + PC_WIDTH'(1);
  assign pc_d     = i_branch_taken ? i_branch_target : pc_plus1;

  pipe_reg #(.W(PC_WIDTH), .RST_VAL(PC_WIDTH'(RESET_PC))) u_pc (
    .clk(clk), .rst(rst), .en(i_branch_taken | i_PCWrite), .clr(1'b0),
    .d(pc_d), .q(o_pc)
  );

  // Flush clears to the NOP encoding; an IF/ID hold keeps valid as-is.
  assign ifid_d = {pc_plus1, i_instruction, 1'b1};

  pipe_reg #(.W(IFID_W), .RST_VAL('0)) u_if_id (
    .clk(clk), .rst(rst), .en(i_if_id_write), .clr(i_branch_taken),
    .d(ifid_d), .q(ifid_q)
  );

  assign o_if_id_pc_plus1    = ifid_q[IFID_W-1 -: PC_WIDTH];
  assign o_if_id_instruction = ifid_q[INST_WIDTH:1];
  assign o_if_id_valid       = ifid_q[0];

  assign idex_d = i_control_mux ? CTRL_WIDTH'(NOP_CTRL) : i_id_control;

  pipe_reg #(.W(CTRL_WIDTH), .RST_VAL('0)) u_id_ex (
    .clk(clk), .rst(rst), .en(1'b1), .clr(i_branch_taken),
    .d(idex_d), .q(o_id_ex_control)
  );

`ifdef FETCH_STALL_COUNTER_EN
  logic [STALL_CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (i_control_mux && !i_branch_taken && stall_cnt != '1)
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

  assign o_stall_count = stall_cnt;
`else
  assign o_stall_count = '0;
`endif

endmodule
